// File: rtl/cpu_reg_bank_if.sv
// Register-bank access bundle: write port, stack port, two read ports and flags.
// The control side uses master; the register bank itself uses slave.
interface cpu_reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int SEL_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [SEL_W-1:0] wr_sel;
  logic [1:0]       wr_op;
  logic [WIDTH-1:0] wr_data;
  logic             sp_push;
  logic             sp_pop;
  logic [SEL_W-1:0] rd_a_sel;
  logic [SEL_W-1:0] rd_b_sel;
  logic [WIDTH-1:0] rd_a_data;
  logic [WIDTH-1:0] rd_b_data;
  logic             flag_z;
  logic             flag_n;

  modport master (
    output wr_sel, wr_op, wr_data, sp_push, sp_pop, rd_a_sel, rd_b_sel,
    input  rd_a_data, rd_b_data, flag_z, flag_n
  );

  modport slave (
    input  wr_sel, wr_op, wr_data, sp_push, sp_pop, rd_a_sel, rd_b_sel,
    output rd_a_data, rd_b_data, flag_z, flag_n
  );
endinterface

// File: rtl/cpu_reg_bank.sv
// 2A03 register bank: indexed A/X/Y/S array with load/inc/dec write port,
// stack-pointer push/pop port, registered Z/N flags and two combinational reads.
module cpu_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter int               NREGS   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               SP_IDX  = 3,
  parameter logic [WIDTH-1:0] SP_RST  = 8'hFD
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu_reg_bank_if.slave      bus
);

  localparam int SEL_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  // A build whose SP_IDX lies outside the array simply has no stack register.
  localparam bit HAS_SP = (SP_IDX >= 0) && (SP_IDX < NREGS);
  localparam int SP_I   = HAS_SP ? SP_IDX : 0;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_DEC  = 2'b11
  } wr_op_e;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             flag_z_q, flag_z_d;
  logic             flag_n_q, flag_n_d;
  logic [WIDTH-1:0] wr_result;
  logic             wr_hit_sp;
  wr_op_e           op;

  assign op = wr_op_e'(bus.wr_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RST : RST_VAL;
      end
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  // Out-of-range wr_sel matches no entry, so it changes neither state nor flags.
  always_comb begin
    regs_d    = regs_q;
    flag_z_d  = flag_z_q;
    flag_n_d  = flag_n_q;
    wr_result = '0;
    wr_hit_sp = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (op != OP_HOLD && bus.wr_sel == SEL_W'(i)) begin
        case (op)
          OP_LOAD: wr_result = bus.wr_data;
          OP_INC:  wr_result = regs_q[i] + WIDTH'(1);
          OP_DEC:  wr_result = regs_q[i] - WIDTH'(1);
          default: wr_result = regs_q[i];
        endcase
        regs_d[i] = wr_result;
        if (i == SP_IDX) begin
          wr_hit_sp = 1'b1;
        end else begin
          flag_z_d = (wr_result == '0);
          flag_n_d = wr_result[WIDTH-1];
        end
      end
    end
    // The write port owns S when it targets it; push and pop together cancel.
    if (HAS_SP && !wr_hit_sp && (bus.sp_push ^ bus.sp_pop)) begin
      regs_d[SP_I] = bus.sp_push ? (regs_q[SP_I] - WIDTH'(1))
                                 : (regs_q[SP_I] + WIDTH'(1));
    end
  end

  always_comb begin
    bus.rd_a_data = '0;
    bus.rd_b_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.rd_a_sel == SEL_W'(i)) bus.rd_a_data = regs_q[i];
      if (bus.rd_b_sel == SEL_W'(i)) bus.rd_b_data = regs_q[i];
    end
  end

  assign bus.flag_z = flag_z_q;
  assign bus.flag_n = flag_n_q;

endmodule
